cordic_mac_unit: RTL and testbench

Responder side of the neuron start/stop MAC handshake. The block accepts one activation/weight pair per `start` pulse and forms the product with an iterative linear-mode CORDIC shift-add, one weight bit per cycle. It adds the product into a 16-bit accumulator and answers with a one-cycle `stop` pulse. It sits between the operand sequencer (the handshake initiator) and the neuron activation stage.

---
 rtl/cordic_mac_pkg.sv | 7 +
 rtl/mac_sat_add.sv | 19 +
 rtl/cordic_mac_unit.sv | 93 +++++++++
 tb/tb_cordic_mac_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/cordic_mac_pkg.sv
// cordic_mac_pkg: shared FSM state type and default sizing for the CORDIC MAC unit.
package cordic_mac_pkg;
    localparam int DW_DEF = 8;
    localparam int AW_DEF = 16;
    localparam int N_ITER = DW_DEF;
    typedef enum logic [1:0] {IDLE, ITER, ACC, DONE} mac_state_t;
endpackage

// File: rtl/mac_sat_add.sv
// mac_sat_add: AW-bit accumulate adder with carry-out.
// MAC_SAT_EN clamps the sum to all-ones on carry; otherwise it wraps and carry reads 0.
module mac_sat_add #(
    parameter int AW = 16
) (
    input  logic [AW-1:0] a_i,
    input  logic [AW-1:0] b_i,
    output logic [AW-1:0] sum_o,
    output logic          co_o
);
`ifdef MAC_SAT_EN
    logic [AW-1:0] raw;
    assign {co_o, raw} = a_i + b_i;
    assign sum_o = co_o ? '1 : raw;
`else
    assign sum_o = a_i + b_i;
    assign co_o  = 1'b0;
`endif
endmodule

// File: rtl/cordic_mac_unit.sv
// cordic_mac_unit: start/stop MAC responder, linear-CORDIC shift-add multiply into an accumulator.
// Optional MAC_SAT_EN: saturating accumulate with sticky ovf (see mac_sat_add).
module cordic_mac_unit
    import cordic_mac_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   acc_clr,
    input  logic [DW-1:0]          a_in,
    input  logic [DW-1:0]          w_in,
    output logic [$clog2(DW)-1:0]  counter,
    output logic                   busy,
    output logic                   stop,
    output logic [AW-1:0]          Zn,
    output logic [AW-1:0]          C,
    output logic                   ovf
);
    localparam int CW = $clog2(DW);
    mac_state_t    state_q;
    logic [DW-1:0] a_q, w_q;
    logic [AW-1:0] y_q, zn_q, c_q, c_d, acc_base;
    logic [CW-1:0] counter_q;
    logic          busy_q, stop_q, ovf_q, ovf_d, co;
    // Clear takes effect before the add, so a cleared ACC edge loads just the product.
    assign acc_base = acc_clr ? '0 : c_q;
    assign ovf_d    = !acc_clr && (ovf_q || co);
    mac_sat_add #(.AW(AW)) u_add (
        .a_i  (acc_base),
        .b_i  (y_q),
        .sum_o(c_d),
        .co_o (co)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            w_q       <= '0;
            y_q       <= '0;
            zn_q      <= '0;
            c_q       <= '0;
            counter_q <= '0;
            busy_q    <= 1'b0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            stop_q <= 1'b0;
            if (acc_clr && state_q != ACC) begin
                c_q   <= '0;
                ovf_q <= 1'b0;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q       <= a_in;
                        w_q       <= w_in;
                        y_q       <= '0;
                        counter_q <= CW'(DW - 1);
                        busy_q    <= 1'b1;
                        state_q   <= ITER;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ITER: begin
                    if (w_q[counter_q])
                        y_q <= y_q + (AW'(a_q) << counter_q);
                    if (counter_q == '0)
                        state_q <= ACC;
                    else
                        counter_q <= counter_q - 1'b1;
                end
                ACC: begin
                    zn_q    <= y_q;
                    c_q     <= c_d;
                    ovf_q   <= ovf_d;
                    busy_q  <= 1'b0;
                    stop_q  <= 1'b1;
                    state_q <= DONE;
                end
            endcase
        end
    end
    assign counter = counter_q;
    assign busy    = busy_q;
    assign stop    = stop_q;
    assign Zn      = zn_q;
    assign C       = c_q;
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_cordic_mac_unit.sv
// tb_cordic_mac_unit: randomized and directed checks of cordic_mac_unit against an arithmetic MAC model.
module tb_cordic_mac_unit;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int CMAX = (1 << AW) - 1;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          acc_clr = 1'b0;
    logic [DW-1:0] a_in = '0;
    logic [DW-1:0] w_in = '0;
    logic [2:0]    counter;
    logic          busy, stop, ovf;
    logic [AW-1:0] Zn, C;
    int n_tests = 0;
    int n_fail = 0;
    int m_c = 0;
    int m_zn = 0;
    int m_ovf = 0;
    cordic_mac_unit #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .acc_clr(acc_clr),
        .a_in   (a_in),
        .w_in   (w_in),
        .counter(counter),
        .busy   (busy),
        .stop   (stop),
        .Zn     (Zn),
        .C      (C),
        .ovf    (ovf)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic void model_acc(input int p, input bit clr);
        int s;
        if (clr) begin
            m_c = 0;
            m_ovf = 0;
        end
        s = m_c + p;
`ifdef MAC_SAT_EN
        if (s > CMAX) begin
            m_c = CMAX;
            m_ovf = 1;
        end else begin
            m_c = s;
        end
`else
        m_c = s % (CMAX + 1);
        m_ovf = 0;
`endif
        m_zn = p;
    endfunction
    // Call at #1 after a rising edge with the DUT in IDLE or in its stop cycle.
    task automatic run_pair(input int a, input int w, input bit clr = 1'b0, input bit inject = 1'b0);
        int cyc;
        bit seen;
        start = 1'b1;
        a_in  = DW'(a);
        w_in  = DW'(w);
        @(posedge clk); #1;
        start = 1'b0;
        check("cnt_load", 32'(counter), 7);
        check("busy_on", 32'(busy), 1);
        model_acc(a * w, clr);
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 4 && inject) begin
                start = 1'b1;
                a_in  = 8'd1;
                w_in  = 8'd1;
            end
            if (cyc == 5) start = 1'b0;
            if (cyc == 8) acc_clr = clr;
            if (cyc == 9) acc_clr = 1'b0;
            if (cyc == 3) check("cnt_iter", 32'(counter), 4);
            seen = stop;
        end
        acc_clr = 1'b0;
        check("latency", cyc, 9);
        check("Zn", 32'(Zn), m_zn);
        check("C", 32'(C), m_c);
        check("ovf", 32'(ovf), m_ovf);
        check("busy_off", 32'(busy), 0);
        check("cnt_end", 32'(counter), 0);
    endtask
    task automatic idle_check(input int n);
        int s = 0;
        repeat (n) begin
            @(posedge clk); #1;
            if (stop) s++;
        end
        check("no_stop", s, 0);
    endtask
    task automatic clear_acc();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_c = 0;
        m_ovf = 0;
        check("clr_C", 32'(C), 0);
        check("clr_ovf", 32'(ovf), 0);
    endtask
    initial begin
        int na[8] = '{23, 58, 25, 46, 51, 76, 18, 92};
        int nw[8] = '{45, 36, 15, 59, 56, 109, 108, 35};
        repeat (2) @(posedge clk);
        #1;
        check("rst_C", 32'(C), 0);
        check("rst_Zn", 32'(Zn), 0);
        check("rst_cnt", 32'(counter), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stop", 32'(stop), 0);
        check("rst_ovf", 32'(ovf), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_pair(23, 45);
        check("single_Zn", 32'(Zn), 1035);
        idle_check(2);
        clear_acc();
        for (int i = 0; i < 8; i++) run_pair(na[i], nw[i]);
        check("neuron_C", 32'(C), 22516);
        check("neuron_ovf", 32'(ovf), 0);
        idle_check(2);
        run_pair(255, 255, 1'b0, 1'b1);
        check("busy_ign_Zn", 32'(Zn), 65025);
        idle_check(12);
        clear_acc();
        run_pair(255, 255);
        run_pair(255, 2);
        run_pair(1, 1);
        run_pair(255, 255);
        run_pair(255, 255);
        idle_check(2);
        clear_acc();
        run_pair(23, 45);
        run_pair(2, 3, 1'b1);
        check("accclr_C", 32'(C), 6);
        idle_check(2);
        start = 1'b1;
        a_in  = 8'd200;
        w_in  = 8'd201;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        m_c = 0;
        m_zn = 0;
        m_ovf = 0;
        check("mid_rst_C", 32'(C), 0);
        check("mid_rst_Zn", 32'(Zn), 0);
        check("mid_rst_cnt", 32'(counter), 0);
        check("mid_rst_busy", 32'(busy), 0);
        @(negedge clk) rst_n = 1'b1;
        idle_check(12);
        run_pair(3, 4);
        check("post_rst_Zn", 32'(Zn), 12);
        for (int i = 0; i < 25; i++) begin
            run_pair(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), $urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) begin
                repeat (int'($urandom_range(1, 3))) begin
                    @(posedge clk); #1;
                end
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
